// File: rtl/typed_rr_arbiter_if.sv
// Handshake bundle between N upstream requesters, the arbiter, and one downstream sink.
// The payload types travel with the interface so the arbiter and its neighbours agree on them.
interface typed_rr_arbiter_if #(
  parameter type T  = bit,
  parameter type R  = T,
  parameter int  N  = 4,
  parameter int  IW = $clog2(N)
);
  logic [N-1:0]  in_valid;
  T              in_data [N];
  logic [N-1:0]  in_ready;
  logic          out_valid;
  R              out_data;
  logic [IW-1:0] out_id;
  logic          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/typed_rr_arbiter.sv
// Round-robin arbiter feeding one registered output slot from N typed requesters.
// The slot refills in the same cycle it drains, sustaining one item per clock.
module typed_rr_arbiter #(
  parameter type T  = bit,
  parameter type R  = T,
  parameter int  N  = 4,
  parameter int  IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  typed_rr_arbiter_if.slave bus,
  output logic [15:0]       grant_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       winner;
  logic                any_valid;
  logic                load_en;
  logic                take;
  logic [$bits(T)-1:0] win_bits;
  R                    out_data_q;
  logic [IW-1:0]       out_id_q;

  assign any_valid = |bus.in_valid;
  assign load_en   = (state == EMPTY) | (bus.out_ready & bus.out_valid);
  assign take      = load_en & any_valid;

  // Scan from ptr upward with wrap; the first requesting index wins.
  always_comb begin
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && bus.in_valid[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  // Payload goes through an unsigned vector so a signed T zero-extends into a wider R.
  assign win_bits = bus.in_data[winner];

  always_comb begin
    bus.in_ready = '0;
    if (rst_n && take) begin
      bus.in_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (take) begin
      state_nxt = FULL;
    end else if (state == FULL && bus.out_ready) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr         <= '0;
      grant_count <= '0;
    end else if (take) begin
      out_data_q  <= R'(win_bits);
      out_id_q    <= winner;
      ptr         <= (winner == IW'(N - 1)) ? '0 : IW'(winner + 1'b1);
      grant_count <= grant_count + 16'd1;
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_typed_rr_arbiter.sv
// Directed bench for typed_rr_arbiter across three type configurations sharing one clock and reset.
// Expected values are hand-computed from the arbitration order and type conversion rules.
module tb_typed_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] gc_a;
  logic [15:0] gc_b;
  logic [15:0] gc_c;
  int          checks;
  int          errors;

  typed_rr_arbiter_if #(.T(int), .R(bit),     .N(4)) ifa ();
  typed_rr_arbiter_if #(.T(bit),              .N(4)) ifb ();
  typed_rr_arbiter_if #(.T(int), .R(longint), .N(4)) ifc ();

  typed_rr_arbiter #(.T(int), .R(bit), .N(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .grant_count(gc_a)
  );

  typed_rr_arbiter #(.T(bit), .N(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .grant_count(gc_b)
  );

  typed_rr_arbiter #(.T(int), .R(longint), .N(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc), .grant_count(gc_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic ready);
    ifa.in_valid  = valid;
    ifa.out_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ifa.in_valid = 4'hF; ifa.out_ready = 1'b0;
    ifb.in_valid = '0;   ifb.out_ready = 1'b0;
    ifc.in_valid = '0;   ifc.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifa.in_data[i] = 10 + i;
      ifb.in_data[i] = 1'b0;
      ifc.in_data[i] = 0;
    end

    // Reset values, with requests present but suppressed while reset is low.
    tick();
    checkOutput("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    checkOutput("rst_out_id",    64'(ifa.out_id),    64'd0);
    checkOutput("rst_out_data",  64'(ifa.out_data),  64'd0);
    checkOutput("rst_grant_cnt", 64'(gc_a),          64'd0);
    checkOutput("rst_in_ready",  64'(ifa.in_ready),  64'd0);

    // All four requesting at full throughput: grants 0,1,2,3,0.
    rst_n = 1'b1;
    applyStimulus(4'hF, 1'b1);
    #1;
    checkOutput("rr_in_ready_first", 64'(ifa.in_ready), 64'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("rr_out_valid", 64'(ifa.out_valid), 64'd1);
      checkOutput("rr_out_id",    64'(ifa.out_id),    64'(k % 4));
      checkOutput("rr_out_data",  64'(ifa.out_data),  64'((10 + k % 4) & 1));
      checkOutput("rr_grant_cnt", 64'(gc_a),          64'(k + 1));
      checkOutput("rr_in_ready",  64'(ifa.in_ready),  64'(4'b0001 << ((k + 1) % 4)));
    end

    // Grant to 2 moves ptr to 3; requesters 0 and 3 then get 3 before wrapping to 0.
    applyStimulus(4'b0100, 1'b1);
    #1;
    checkOutput("wrap_in_ready_r2", 64'(ifa.in_ready), 64'b0100);
    tick();
    checkOutput("wrap_id_r2",       64'(ifa.out_id),   64'd2);
    checkOutput("wrap_cnt_r2",      64'(gc_a),         64'd6);
    applyStimulus(4'b1001, 1'b1);
    #1;
    checkOutput("wrap_in_ready_r3", 64'(ifa.in_ready), 64'b1000);
    tick();
    checkOutput("wrap_id_r3",       64'(ifa.out_id),   64'd3);
    checkOutput("wrap_data_r3",     64'(ifa.out_data), 64'd1);
    checkOutput("wrap_in_ready_r0", 64'(ifa.in_ready), 64'b0001);
    tick();
    checkOutput("wrap_id_r0",       64'(ifa.out_id),   64'd0);
    checkOutput("wrap_cnt_r0",      64'(gc_a),         64'd8);

    // Idle cycle drains the slot without moving ptr or the count.
    applyStimulus(4'b0000, 1'b1);
    #1;
    checkOutput("idle_in_ready",  64'(ifa.in_ready),  64'd0);
    tick();
    checkOutput("idle_out_valid", 64'(ifa.out_valid), 64'd0);
    checkOutput("idle_out_id",    64'(ifa.out_id),    64'd0);
    checkOutput("idle_grant_cnt", 64'(gc_a),          64'd8);
    applyStimulus(4'hF, 1'b1);
    #1;
    checkOutput("idle_ptr_kept",  64'(ifa.in_ready),  64'b0010);
    applyStimulus(4'h0, 1'b1);

    // Single requester against a stalled sink, then drain with same-cycle reload.
    ifb.in_data[2] = 1'b1;
    ifb.in_valid   = 4'b0100;
    ifb.out_ready  = 1'b0;
    #1;
    checkOutput("stall_in_ready_0", 64'(ifb.in_ready), 64'b0100);
    tick();
    checkOutput("stall_valid_0", 64'(ifb.out_valid), 64'd1);
    checkOutput("stall_id_0",    64'(ifb.out_id),    64'd2);
    checkOutput("stall_data_0",  64'(ifb.out_data),  64'd1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("stall_in_ready", 64'(ifb.in_ready),  64'd0);
      checkOutput("stall_valid",    64'(ifb.out_valid), 64'd1);
      checkOutput("stall_id",       64'(ifb.out_id),    64'd2);
      checkOutput("stall_cnt",      64'(gc_b),          64'd1);
      tick();
    end
    ifb.out_ready = 1'b1;
    #1;
    checkOutput("reload_in_ready", 64'(ifb.in_ready),  64'b0100);
    tick();
    checkOutput("reload_valid",    64'(ifb.out_valid), 64'd1);
    checkOutput("reload_cnt",      64'(gc_b),          64'd2);
    ifb.in_valid = 4'b0000;
    tick();
    checkOutput("drain_valid",     64'(ifb.out_valid), 64'd0);
    checkOutput("drain_data_held", 64'(ifb.out_data),  64'd1);
    checkOutput("drain_id_held",   64'(ifb.out_id),    64'd2);
    checkOutput("drain_cnt",       64'(gc_b),          64'd2);

    // Signed int into longint must zero-extend.
    ifc.in_data[1] = 32'hFFFF_0001;
    ifc.in_data[3] = 32'h0000_00A5;
    ifc.in_valid   = 4'b0010;
    ifc.out_ready  = 1'b1;
    tick();
    checkOutput("wide_data_r1", ifc.out_data,       64'h0000_0000_FFFF_0001);
    checkOutput("wide_id_r1",   64'(ifc.out_id),    64'd1);
    ifc.in_valid = 4'b1000;
    tick();
    checkOutput("wide_data_r3", ifc.out_data,       64'h0000_0000_0000_00A5);
    checkOutput("wide_id_r3",   64'(ifc.out_id),    64'd3);
    checkOutput("wide_cnt",     64'(gc_c),          64'd2);
    ifc.in_valid = 4'b0000;

    // Fill the slot under back-pressure, then reset mid-cycle.
    applyStimulus(4'hF, 1'b0);
    tick();
    checkOutput("pre_rst_valid",    64'(ifa.out_valid), 64'd1);
    checkOutput("pre_rst_id",       64'(ifa.out_id),    64'd1);
    checkOutput("pre_rst_in_ready", 64'(ifa.in_ready),  64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 64'(ifa.out_valid), 64'd0);
    checkOutput("async_rst_id",    64'(ifa.out_id),    64'd0);
    checkOutput("async_rst_cnt",   64'(gc_a),          64'd0);
    checkOutput("async_rst_ready", 64'(ifa.in_ready),  64'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(4'hF, 1'b1);
    #1;
    checkOutput("post_rst_in_ready", 64'(ifa.in_ready), 64'b0001);

    // 65536 back-to-back grants wrap the 16-bit count to zero.
    repeat (65536) tick();
    checkOutput("cnt_wrap",      64'(gc_a),          64'd0);
    checkOutput("cnt_wrap_id",   64'(ifa.out_id),    64'd3);
    checkOutput("cnt_wrap_vld",  64'(ifa.out_valid), 64'd1);
    tick();
    checkOutput("cnt_after",     64'(gc_a),          64'd1);
    checkOutput("cnt_after_id",  64'(ifa.out_id),    64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/typed_rr_arbiter.md
Name: typed_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready channel among N upstream requesters.
- Payload element type is a type parameter. Output payload type is a second type parameter that defaults to the input type.
- Registered single-entry output stage.
- Sits in front of any shared sink (bus port, FIFO write side). Exercises type-parameter overrides and dependent type defaults through a real sequential datapath.

Parameters:
- T, bit, type of each requester's payload
- R, T, type of the granted output payload; T value converted to R by SV assignment rules (truncate or zero-extend)
- N, 4, number of requesters, 2..16
- IW, $clog2(N), width of the granted-requester index

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  N  per-requester request
- in_data  input  N x T (unpacked array)  per-requester payload
- in_ready  output  N  per-requester accept; one-hot or zero
- out_valid  output  1  output stage holds a granted item
- out_data  output  R  granted payload
- out_id  output  IW  index of the requester that supplied out_data
- out_ready  input  1  downstream accept
- grant_count  output  16  number of completed input handshakes

Behaviour:
- Reset: asynchronous on rst_n low.
  - out_valid=0, out_data='0, out_id=0, rr pointer ptr=0, grant_count=0, state=EMPTY.
  - in_ready=0 while rst_n low.
- State machine, 2 states:
  - EMPTY: output register empty.
  - FULL: output register holds an item.
  - out_valid = (state==FULL).
- load_en = (state==EMPTY) | (out_ready & out_valid). Same-cycle drain and refill is allowed, giving one item per cycle at full throughput.
- Winner selection: the first i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
- in_ready[winner] = load_en & |in_valid. All other in_ready bits are 0. in_ready is combinational.
- On an input handshake at edge k (load_en, winner w):
  - out_data <= R'(in_data[w]), out_id <= w.
  - State goes to FULL.
  - ptr <= (w+1) mod N; when w = N-1, ptr wraps to 0.
  - grant_count increments by 1 and wraps from 65535 to 0.
  - Item is visible at cycle k+1 (latency 1).
- Output handshake (out_valid & out_ready) with no new winner: state goes to EMPTY; out_data and out_id hold their last values.
- out_valid=1 & out_ready=0: out_data, out_id, ptr and grant_count are all stable. in_ready=0 for every requester.
- No in_valid and load_en: ptr is unchanged and no count is taken.
- Requesters must hold in_valid/in_data until in_ready. The arbiter does not check this.
- Reset asserted mid-transfer drops the held item. No partial state survives.
- Fairness: a continuously requesting requester is granted within N input handshakes.

Test Plan:
- T=int, R=bit, N=4. Reset, then all 4 requesters valid with data 10,11,12,13 and out_ready=1 → out_id sequence 0,1,2,3,0 on consecutive cycles. out_data bits 0,1,0,1. grant_count=4 after 4 cycles.
- T=bit, R=T. Only requester 2 valid, out_ready=0 for 3 cycles → item accepted once, out_valid stays high, in_ready all 0 for 3 cycles. Then out_ready=1 → one output handshake; if requester 2 is still valid, it is reloaded in the same cycle.
- N=4, ptr=3 after a grant to requester 2. Requesters 0 and 3 valid → 3 granted, then 0. Covers pointer wrap.
- T=int, R=longint. in_data[1]=32'hFFFF_0001 → out_data=64'h0000_0000_FFFF_0001.
- grant_count preset by driving 65536 grants → reads 0. Assert rst_n low mid-FULL → out_valid falls asynchronously, ptr=0, next grant starts at requester 0.
